// File: rtl/clock_pkg.sv
// ============================================================================
// Module      : clock_pkg
// Description : Shared field indices, BCD field limits and the packed BCD type
//               used by the time keeping datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    typedef logic [7:0] bcd8_t;

    localparam int SEC_IDX = 0;
    localparam int MIN_IDX = 1;
    localparam int HR_IDX  = 2;

    localparam bcd8_t SEC_MAX = 8'h59;
    localparam bcd8_t MIN_MAX = 8'h59;
    localparam bcd8_t HR_MAX  = 8'h23;

endpackage

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// Module      : bcd_mod_counter
// Description : Two-digit packed BCD counter that wraps from MAX to 00 and
//               flags a carry on the increment that wraps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter bcd8_t MAX = SEC_MAX
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Inc,
    output logic [7:0] Value,
    output logic       Carry
);

    bcd8_t r_value;
    bcd8_t w_next;

    always_comb begin
        w_next = {r_value[7:4], r_value[3:0] + 4'd1};
        if (r_value == MAX) begin
            w_next = 8'h00;
        end else if (r_value[3:0] == 4'd9) begin
            w_next = {r_value[7:4] + 4'd1, 4'h0};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_value <= 8'h00;
        end else if (Inc) begin
            r_value <= w_next;
        end
    end

    assign Value = r_value;
    assign Carry = Inc & (r_value == MAX);

endmodule

`default_nettype wire

// File: rtl/time_keeper.sv
// ============================================================================
// Module      : time_keeper
// Description : 24-hour HH:MM:SS keeper with 1 Hz run mode and per-field edit
//               increments. Optional macro BLINK_EN adds a 2 Hz field blanker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 25000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Editing,
    input  logic [2:0] Digit,
    input  logic       IncrementDigit,
    output logic [7:0] Hours,
    output logic [7:0] Minutes,
    output logic [7:0] Seconds,
    output logic       SecondTick,
    output logic [2:0] BlinkMask
);

    localparam int PRESC_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] r_presc;
    logic               r_tick;
    logic               w_term;
    logic               w_sec_inc, w_min_inc, w_hr_inc;
    logic               w_sec_carry, w_min_carry;
    logic               w_unused_day_carry;

    assign w_term = !Editing && (r_presc == c_presc_last);

    // Edit mode holds the prescaler at 0 so a fresh full second follows exit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_term;
            if (Editing || w_term) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRESC_W'(1);
            end
        end
    end

    assign SecondTick = r_tick;

    // Run mode ripples carries between fields; edit mode increments fields independently.
    assign w_sec_inc = Editing ? (IncrementDigit & Digit[SEC_IDX]) : w_term;
    assign w_min_inc = Editing ? (IncrementDigit & Digit[MIN_IDX]) : w_sec_carry;
    assign w_hr_inc  = Editing ? (IncrementDigit & Digit[HR_IDX])  : w_min_carry;

    bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
        .CLK   (CLK),
        .RST   (RST),
        .Inc   (w_sec_inc),
        .Value (Seconds),
        .Carry (w_sec_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
        .CLK   (CLK),
        .RST   (RST),
        .Inc   (w_min_inc),
        .Value (Minutes),
        .Carry (w_min_carry)
    );

    bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
        .CLK   (CLK),
        .RST   (RST),
        .Inc   (w_hr_inc),
        .Value (Hours),
        .Carry (w_unused_day_carry)
    );

`ifdef BLINK_EN
    localparam int BLINK_DIV = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 1;
    localparam int BLINK_W   = $clog2(BLINK_DIV + 1);

    logic [BLINK_W-1:0] r_bcnt;
    logic [BLINK_W-1:0] w_bcnt_nxt;
    logic               r_blink;
    logic               w_blink_nxt;
    logic [2:0]         r_mask;

    // An increment restarts the phase so the edited field shows at once.
    always_comb begin
        w_bcnt_nxt  = r_bcnt + BLINK_W'(1);
        w_blink_nxt = r_blink;
        if (!Editing || IncrementDigit) begin
            w_bcnt_nxt  = '0;
            w_blink_nxt = 1'b0;
        end else if (r_bcnt == BLINK_W'(BLINK_DIV - 1)) begin
            w_bcnt_nxt  = '0;
            w_blink_nxt = ~r_blink;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
            r_mask  <= 3'b000;
        end else begin
            r_bcnt  <= w_bcnt_nxt;
            r_blink <= w_blink_nxt;
            r_mask  <= Editing ? (Digit & {3{w_blink_nxt}}) : 3'b000;
        end
    end

    assign BlinkMask = r_mask;
`else
    assign BlinkMask = 3'b000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_keeper.sv
// ============================================================================
// Module      : tb_time_keeper
// Description : Self-checking bench for time_keeper against a seconds-of-day
//               reference model; covers BLINK_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_keeper;

    localparam int CLK_HZ    = 4;
    localparam int BLINK_DIV = (CLK_HZ / 4 > 1) ? CLK_HZ / 4 : 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Editing = 1'b0;
    logic [2:0] Digit = 3'b000;
    logic       IncrementDigit = 1'b0;
    logic [7:0] Hours, Minutes, Seconds;
    logic       SecondTick;
    logic [2:0] BlinkMask;

    int checks = 0;
    int errors = 0;

    int         m_h, m_m, m_s, m_cnt, m_k;
    logic       m_tick;
    logic [2:0] m_mask;

    time_keeper #(.CLK_HZ(CLK_HZ)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Editing        (Editing),
        .Digit          (Digit),
        .IncrementDigit (IncrementDigit),
        .Hours          (Hours),
        .Minutes        (Minutes),
        .Seconds        (Seconds),
        .SecondTick     (SecondTick),
        .BlinkMask      (BlinkMask)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_cnt = 0; m_k = 0;
        m_tick = 1'b0; m_mask = 3'b000;
    endtask

    // Advances one clock edge, updates the reference model from the inputs seen at that edge.
    task automatic step();
        int t;
        @(posedge CLK);
        m_tick = 1'b0;
        if (Editing) begin
            m_cnt = 0;
            if (IncrementDigit) begin
                if (Digit[0]) m_s = (m_s + 1) % 60;
                if (Digit[1]) m_m = (m_m + 1) % 60;
                if (Digit[2]) m_h = (m_h + 1) % 24;
            end
        end else begin
            m_cnt++;
            if (m_cnt == CLK_HZ) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                t   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
                m_h = t / 3600;
                m_m = (t / 60) % 60;
                m_s = t % 60;
            end
        end
`ifdef BLINK_EN
        if (!Editing || IncrementDigit) m_k = 0;
        else m_k++;
        m_mask = Editing ? (Digit & {3{1'((m_k / BLINK_DIV) % 2)}}) : 3'b000;
`endif
        #1;
    endtask

    task automatic pulse(input logic [2:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            Digit = d;
            IncrementDigit = 1'b1;
            step();
        end
        IncrementDigit = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; Editing = 1'b0; Digit = 3'b000; IncrementDigit = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({Hours, Minutes, Seconds} !== 24'h000000) begin
            errors++;
            $display("FAIL reset_time: got %h:%h:%h want 00:00:00", Hours, Minutes, Seconds);
        end
        checks++;
        if ({SecondTick, BlinkMask} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got tick=%b mask=%b want 0/000", SecondTick, BlinkMask);
        end
        RST = 1'b1;
    endtask

    task automatic test_run();
        Editing = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (SecondTick !== (((i + 1) % CLK_HZ) == 0) || SecondTick !== m_tick) begin
                errors++;
                $display("FAIL run_tick cycle %0d: got %b want %b", i + 1, SecondTick, m_tick);
            end
            checks++;
            if ({Hours, Minutes, Seconds} !== {bcd(m_h), bcd(m_m), bcd(m_s)}) begin
                errors++;
                $display("FAIL run_time cycle %0d: got %h:%h:%h want %h:%h:%h", i + 1,
                         Hours, Minutes, Seconds, bcd(m_h), bcd(m_m), bcd(m_s));
            end
        end
        checks++;
        if ({Hours, Minutes, Seconds} !== 24'h000003) begin
            errors++;
            $display("FAIL run_12_cycles: got %h:%h:%h want 00:00:03", Hours, Minutes, Seconds);
        end
    endtask

    task automatic test_day_wrap();
        int ticks = 0;
        Editing = 1'b1;
        step();
        pulse(3'b100, (23 - m_h + 24) % 24);
        pulse(3'b010, (59 - m_m + 60) % 60);
        pulse(3'b001, (58 - m_s + 60) % 60);
        step();
        checks++;
        if ({Hours, Minutes, Seconds} !== 24'h235958) begin
            errors++;
            $display("FAIL edit_set: got %h:%h:%h want 23:59:58", Hours, Minutes, Seconds);
        end
        Editing = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (SecondTick === 1'b1) ticks++;
            checks++;
            if ({Hours, Minutes, Seconds, SecondTick} !== {bcd(m_h), bcd(m_m), bcd(m_s), m_tick}) begin
                errors++;
                $display("FAIL wrap_cycle %0d: got %h:%h:%h t=%b want %h:%h:%h t=%b", i + 1,
                         Hours, Minutes, Seconds, SecondTick, bcd(m_h), bcd(m_m), bcd(m_s), m_tick);
            end
            if (i == 3) begin
                checks++;
                if ({Hours, Minutes, Seconds} !== 24'h235959) begin
                    errors++;
                    $display("FAIL wrap_first: got %h:%h:%h want 23:59:59", Hours, Minutes, Seconds);
                end
            end
        end
        checks++;
        if ({Hours, Minutes, Seconds} !== 24'h000000 || ticks != 2) begin
            errors++;
            $display("FAIL wrap_midnight: got %h:%h:%h ticks=%0d want 00:00:00 ticks=2",
                     Hours, Minutes, Seconds, ticks);
        end
    endtask

    task automatic test_edit_modulo();
        logic [7:0] s0, m0, h0;
        Editing = 1'b1;
        step();
        s0 = Seconds; m0 = Minutes; h0 = Hours;
        pulse(3'b001, 60);
        step();
        checks++;
        if (Seconds !== s0 || Minutes !== m0) begin
            errors++;
            $display("FAIL edit_sec_mod60: got s=%h m=%h want s=%h m=%h", Seconds, Minutes, s0, m0);
        end
        pulse(3'b100, 24);
        step();
        checks++;
        if (Hours !== h0 || {Hours, Minutes, Seconds} !== {bcd(m_h), bcd(m_m), bcd(m_s)}) begin
            errors++;
            $display("FAIL edit_hr_mod24: got %h want %h", Hours, h0);
        end
    endtask

    task automatic test_ignore_and_freeze();
        logic [23:0] snap;
        logic        saw_tick = 1'b0;
        logic        moved = 1'b0;
        Editing = 1'b0;
        Digit = 3'b010;
        IncrementDigit = 1'b1;
        step();
        IncrementDigit = 1'b0;
        step();
        checks++;
        if (Minutes !== bcd(m_m) || Minutes !== 8'h00) begin
            errors++;
            $display("FAIL run_inc_ignored: got minutes %h want %h", Minutes, bcd(m_m));
        end
        Editing = 1'b1;
        step();
        snap = {Hours, Minutes, Seconds};
        for (int i = 0; i < 100; i++) begin
            step();
            if (SecondTick !== 1'b0) saw_tick = 1'b1;
            if ({Hours, Minutes, Seconds} !== snap) moved = 1'b1;
        end
        checks++;
        if (saw_tick || moved) begin
            errors++;
            $display("FAIL edit_freeze: got tick=%b moved=%b want 0/0", saw_tick, moved);
        end
    endtask

    task automatic test_back_to_back();
        Editing = 1'b1;
        Digit = 3'b111;
        IncrementDigit = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if ({Hours, Minutes, Seconds} !== {bcd(m_h), bcd(m_m), bcd(m_s)}) begin
                errors++;
                $display("FAIL back_to_back %0d: got %h:%h:%h want %h:%h:%h", i,
                         Hours, Minutes, Seconds, bcd(m_h), bcd(m_m), bcd(m_s));
            end
        end
        IncrementDigit = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) Editing = ~Editing;
            Digit = 3'($urandom);
            IncrementDigit = ($urandom_range(0, 3) == 0);
            step();
            checks++;
            if ({Hours, Minutes, Seconds, SecondTick, BlinkMask} !==
                {bcd(m_h), bcd(m_m), bcd(m_s), m_tick, m_mask}) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random %0d: got %h:%h:%h t=%b b=%b want %h:%h:%h t=%b b=%b", i,
                             Hours, Minutes, Seconds, SecondTick, BlinkMask,
                             bcd(m_h), bcd(m_m), bcd(m_s), m_tick, m_mask);
                bad++;
            end
        end
        Editing = 1'b0;
        IncrementDigit = 1'b0;
    endtask

    task automatic test_async_reset();
        Editing = 1'b1;
        step();
        pulse(3'b100, (12 - m_h + 24) % 24);
        pulse(3'b010, (34 - m_m + 60) % 60);
        pulse(3'b001, (56 - m_s + 60) % 60);
        Editing = 1'b0;
        step();
        step();
        checks++;
        if ({Hours, Minutes, Seconds} !== 24'h123456) begin
            errors++;
            $display("FAIL async_preset: got %h:%h:%h want 12:34:56", Hours, Minutes, Seconds);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({Hours, Minutes, Seconds, SecondTick, BlinkMask} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset: got %h:%h:%h t=%b b=%b want all zero",
                     Hours, Minutes, Seconds, SecondTick, BlinkMask);
        end
        model_reset();
        @(posedge CLK);
        #1 RST = 1'b1;
        for (int i = 0; i < CLK_HZ; i++) begin
            step();
            checks++;
            if ({Seconds, SecondTick} !== {bcd(m_s), m_tick}) begin
                errors++;
                $display("FAIL after_reset %0d: got s=%h t=%b want s=%h t=%b", i + 1,
                         Seconds, SecondTick, bcd(m_s), m_tick);
            end
        end
        checks++;
        if ({Seconds, SecondTick} !== {8'h01, 1'b1}) begin
            errors++;
            $display("FAIL resume_first_tick: got s=%h t=%b want 01/1", Seconds, SecondTick);
        end
    endtask

    task automatic test_blink();
        Editing = 1'b1;
        Digit = 3'b010;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (BlinkMask !== m_mask) begin
                errors++;
                $display("FAIL blink %0d: got %b want %b", i, BlinkMask, m_mask);
            end
        end
        IncrementDigit = 1'b1;
        step();
        IncrementDigit = 1'b0;
        checks++;
        if (BlinkMask !== 3'b000) begin
            errors++;
            $display("FAIL blink_restart: got %b want 000", BlinkMask);
        end
        Editing = 1'b0;
        step();
        checks++;
        if (BlinkMask !== 3'b000) begin
            errors++;
            $display("FAIL blink_run: got %b want 000", BlinkMask);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_day_wrap();
        test_edit_modulo();
        test_ignore_and_freeze();
        test_back_to_back();
        test_blink();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
